// File: rtl/seven_seg_capture.sv
// seven_seg_capture: debounces 7-segment samples per digit position and captures BCD codes.
// Optional sticky illegal-pattern flag is enabled by defining SEVEN_SEG_CAPTURE_PATTERN_ERR_EN.
module seven_seg_capture #(
  parameter int STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  digit_sel,
  input  logic        sample_en,
  input  logic        err_clr,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        pattern_err
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  localparam logic [3:0] STABLE = 4'(STABLE_CNT);
  state_t     r_state;
  logic [6:0] r_prev_seg;
  logic [3:0] r_prev_sel, r_cnt, r_mask;
  logic [3:0] w_code, w_cnt_inc;
  logic [1:0] w_idx;
  logic       w_onehot, w_same, w_cap;
  always_comb begin
    case (seg_in)
      7'b1111110: w_code = 4'd0;
      7'b0110000: w_code = 4'd1;
      7'b1101101: w_code = 4'd2;
      7'b1111001: w_code = 4'd3;
      7'b0110011: w_code = 4'd4;
      7'b1011011: w_code = 4'd5;
      7'b1011111: w_code = 4'd6;
      7'b1110000: w_code = 4'd7;
      7'b1111111: w_code = 4'd8;
      7'b1111011: w_code = 4'd9;
      7'b0000001: w_code = 4'hF;
      default:    w_code = 4'hE;
    endcase
  end
  assign w_onehot  = $onehot(digit_sel);
  assign w_same    = (seg_in == r_prev_seg) && (digit_sel == r_prev_sel);
  assign w_cnt_inc = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;
  assign w_idx     = digit_sel[3] ? 2'd3 : digit_sel[2] ? 2'd2 : digit_sel[1] ? 2'd1 : 2'd0;
  assign w_cap     = sample_en && w_onehot && w_same && (r_state == SETTLE) && (w_cnt_inc == STABLE);
  // A capture landing on the frame boundary seeds the fresh mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_prev_seg  <= 7'd0;
      r_prev_sel  <= 4'd0;
      r_mask      <= 4'd0;
      bcd_out     <= 16'hFFFF;
      digit_valid <= 4'd0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= (r_mask == 4'hF);
      r_mask     <= ((r_mask == 4'hF) ? 4'h0 : r_mask) | (w_cap ? digit_sel : 4'h0);
      if (sample_en) begin
        if (!w_onehot) begin
          r_cnt   <= 4'd0;
          r_state <= IDLE;
        end else if (!w_same || r_state == IDLE) begin
          r_prev_seg <= seg_in;
          r_prev_sel <= digit_sel;
          r_cnt      <= 4'd1;
          r_state    <= SETTLE;
        end else if (r_state == SETTLE) begin
          r_cnt <= w_cnt_inc;
          if (w_cap) r_state <= HELD;
        end
      end
      if (w_cap) begin
        bcd_out[{w_idx, 2'b00} +: 4] <= w_code;
        digit_valid[w_idx]           <= (w_code < 4'd10);
      end
    end
  end
`ifdef SEVEN_SEG_CAPTURE_PATTERN_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pattern_err <= 1'b0;
    else if (w_cap && w_code == 4'hE) pattern_err <= 1'b1;
    else if (err_clr) pattern_err <= 1'b0;
  end
`else
  logic w_unused;
  assign w_unused    = err_clr;
  assign pattern_err = 1'b0;
`endif
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed and randomized checks against a run-length behavioural model.
module tb_seven_seg_capture;
  localparam int STABLE_CNT = 3;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg_in = 7'd0;
  logic [3:0]  digit_sel = 4'd0;
  logic        sample_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] bcd_out;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        pattern_err;
  int n_vec = 0;
  int n_err = 0;
  logic [6:0] pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  seven_seg_capture #(.STABLE_CNT(STABLE_CNT)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .digit_sel(digit_sel),
    .sample_en(sample_en), .err_clr(err_clr), .bcd_out(bcd_out),
    .digit_valid(digit_valid), .frame_done(frame_done), .pattern_err(pattern_err)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] decode(input logic [6:0] s);
    decode = (s == 7'b0000001) ? 4'hF : 4'hE;
    for (int k = 0; k < 10; k++) if (pats[k] == s) decode = 4'(k);
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a digit is captured when the run of identical one-hot samples hits exactly STABLE_CNT.
  logic [3:0] m_dig [4] = '{default: 4'hF};
  logic [3:0] m_val = 4'd0, m_seen = 4'd0;
  logic       m_frame = 1'b0, m_err = 1'b0;
  logic [6:0] m_last_seg = 7'd0;
  logic [3:0] m_last_sel = 4'd0;
  int         m_run = 0;
  always @(posedge clk or negedge reset_n) begin : model
    int pos;
    logic cap;
    logic [3:0] code;
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) m_dig[k] = 4'hF;
      m_val = 0; m_seen = 0; m_frame = 0; m_err = 0; m_run = 0; m_last_seg = 0; m_last_sel = 0;
    end else begin
      cap = 1'b0;
      pos = 0;
      for (int k = 0; k < 4; k++) if (digit_sel[k]) pos = k;
      if (sample_en) begin
        if ($countones(digit_sel) != 1) m_run = 0;
        else begin
          if (m_run > 0 && seg_in == m_last_seg && digit_sel == m_last_sel) m_run = (m_run < 1000) ? m_run + 1 : m_run;
          else m_run = 1;
          m_last_seg = seg_in;
          m_last_sel = digit_sel;
          cap = (m_run == STABLE_CNT);
        end
      end
      m_frame = (m_seen == 4'hF);
      if (m_frame) m_seen = 4'h0;
      code = decode(seg_in);
      if (cap) begin
        m_dig[pos] = code;
        m_val[pos] = (code < 4'd10);
        m_seen[pos] = 1'b1;
      end
`ifdef SEVEN_SEG_CAPTURE_PATTERN_ERR_EN
      if (cap && code == 4'hE) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
`endif
    end
  end
  always @(negedge clk) begin
    chk("bcd_out", bcd_out, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk("digit_valid", {12'd0, digit_valid}, {12'd0, m_val});
    chk("frame_done", {15'd0, frame_done}, {15'd0, m_frame});
    chk("pattern_err", {15'd0, pattern_err}, {15'd0, m_err});
  end
  task automatic cyc(input logic [3:0] sel, input logic [6:0] seg, input logic en, input logic clr);
    digit_sel = sel; seg_in = seg; sample_en = en; err_clr = clr;
    @(negedge clk);
    #1;
  endtask
  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) cyc(sel, seg, 1'b1, 1'b0);
  endtask
  initial begin
    logic [3:0] rsel;
    logic [6:0] rseg;
    int r;
    repeat (2) @(negedge clk);
    #1;
    chk("reset bcd", bcd_out, 16'hFFFF);
    chk("reset valid", {12'd0, digit_valid}, 16'd0);
    chk("reset frame", {15'd0, frame_done}, 16'd0);
    chk("reset err", {15'd0, pattern_err}, 16'd0);
    reset_n = 1'b1;
    hold(4'b0001, 7'b1111001, 2);
    chk("d0 after 2", {12'd0, bcd_out[3:0]}, 16'hF);
    hold(4'b0001, 7'b1111001, 1);
    chk("d0 after 3", {12'd0, bcd_out[3:0]}, 16'h3);
    chk("d0 valid", {15'd0, digit_valid[0]}, 16'd1);
    for (int k = 0; k < 8; k++) cyc(4'b0010, k[0] ? 7'b1111111 : 7'b0110000, 1'b1, 1'b0);
    chk("toggle d1", {12'd0, bcd_out[7:4]}, 16'hF);
    hold(4'b0001, 7'b0110000, 3);
    hold(4'b0010, 7'b1101101, 3);
    hold(4'b0100, 7'b1111001, 3);
    hold(4'b1000, 7'b0110011, 3);
    chk("frame pre", {15'd0, frame_done}, 16'd0);
    cyc(4'b1000, 7'b0110011, 1'b0, 1'b0);
    chk("frame pulse", {15'd0, frame_done}, 16'd1);
    chk("frame bcd", bcd_out, 16'h4321);
    cyc(4'b1000, 7'b0110011, 1'b0, 1'b0);
    chk("frame end", {15'd0, frame_done}, 16'd0);
    for (int k = 0; k < 6; k++) cyc(4'($urandom), 7'($urandom), 1'b0, 1'b0);
    chk("en low bcd", bcd_out, 16'h4321);
    hold(4'b0100, 7'b1010101, 3);
    chk("illegal code", {12'd0, bcd_out[11:8]}, 16'hE);
    chk("illegal valid", {15'd0, digit_valid[2]}, 16'd0);
`ifdef SEVEN_SEG_CAPTURE_PATTERN_ERR_EN
    chk("err set", {15'd0, pattern_err}, 16'd1);
    hold(4'b1000, 7'b1010100, 2);
    cyc(4'b1000, 7'b1010100, 1'b1, 1'b1);
    chk("err set+clr", {15'd0, pattern_err}, 16'd1);
    cyc(4'b1000, 7'b1010100, 1'b0, 1'b1);
    chk("err clr", {15'd0, pattern_err}, 16'd0);
`else
    chk("err tied", {15'd0, pattern_err}, 16'd0);
`endif
    hold(4'b0011, 7'b1111111, 5);
    chk("non-onehot", {12'd0, bcd_out[3:0]}, 16'h1);
    hold(4'b0001, 7'b1111111, 2);
    reset_n = 1'b0;
    #1;
    chk("async rst bcd", bcd_out, 16'hFFFF);
    chk("async rst valid", {12'd0, digit_valid}, 16'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    hold(4'b0001, 7'b1111111, 2);
    chk("post rst 2", {12'd0, bcd_out[3:0]}, 16'hF);
    hold(4'b0001, 7'b1111111, 1);
    chk("post rst 3", {12'd0, bcd_out[3:0]}, 16'h8);
    rsel = 4'b0001;
    rseg = pats[0];
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        rsel = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom);
        r = $urandom_range(0, 12);
        rseg = (r < 10) ? pats[r] : (r == 10) ? 7'b0000001 : (r == 11) ? 7'b1010101 : 7'($urandom);
      end
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
      cyc(rsel, rseg, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 3, range 2..15: number of consecutive identical samples needed to capture a digit.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port seg_in, input, 7, segment pattern a..g (bit6=a, bit0=g, 1=lit).
REQ-005 SHALL have port digit_sel, input, 4, one-hot digit-position select (bit i = digit i).
REQ-006 SHALL have port sample_en, input, 1, sample strobe; inputs are ignored when low.
REQ-007 SHALL have port err_clr, input, 1, clears pattern_err.
REQ-008 SHALL have port bcd_out, output, 16, captured digits (digit i at bits 4i+3:4i).
REQ-009 SHALL have port digit_valid, output, 4, bit i = digit i holds a legal 0-9 code.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse after all four positions are captured.
REQ-011 SHALL have port pattern_err, output, 1, sticky illegal-pattern flag.

Function
REQ-012 SHALL map patterns to codes: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 0000001 (dash)->4'hF blank; any other pattern->4'hE illegal.
REQ-013 SHALL use a state machine IDLE, SETTLE, HELD, advanced only on cycles with sample_en=1.
REQ-014 SHALL, when digit_sel is not one-hot, clear the stability count, capture nothing, and go to IDLE.
REQ-015 SHALL, when digit_sel or seg_in differs from the previous sample, register both as the new previous value, set the count to 1, and go to SETTLE.
REQ-016 SHALL, in SETTLE on an identical sample, increment the count; when it reaches STABLE_CNT, capture and go to HELD.
REQ-017 SHALL, in HELD on an identical sample, hold with no recapture and no count change.
REQ-018 SHALL update the captured slot of bcd_out and digit_valid at the clock edge that accepts the STABLE_CNT-th identical sample.
REQ-019 SHALL set digit_valid[i] to 1 for codes 0-9 and to 0 for blank or illegal codes; other slots are unchanged.
REQ-020 SHALL keep a seen mask of positions captured since the last frame_done.
REQ-021 SHALL pulse frame_done for exactly one cycle, the cycle after the mask reaches 4'b1111, and clear the mask in that same cycle.
REQ-022 SHALL, when a capture coincides with the mask clear, record that capture in the new mask.
REQ-023 SHALL keep the stability count saturating and never wrapping.

Reset
REQ-024 SHALL, while reset_n=0, immediately force: bcd_out=16'hFFFF, digit_valid=0, frame_done=0, pattern_err=0, mask=0, count=0, previous sample=0, state IDLE.
REQ-025 SHALL, when reset is asserted during SETTLE, lose the pending capture; capture restarts from the first sample after release.

Configuration
REQ-026 SHALL, with macro SEVEN_SEG_CAPTURE_PATTERN_ERR_EN defined, set pattern_err on each illegal-code capture and clear it on err_clr=1; a simultaneous set and clear SHALL leave it set.
REQ-027 SHALL, without SEVEN_SEG_CAPTURE_PATTERN_ERR_EN, tie pattern_err to 0 and ignore err_clr; illegal patterns are still captured as 4'hE.

Verification
REQ-028 SHALL check, with STABLE_CNT=3, digit_sel=0001, seg_in=1111001 and sample_en=1 for 3 cycles: bcd_out[3:0]=3 and digit_valid[0]=1 after the 3rd edge, and no change after the 2nd.
REQ-029 SHALL check seg_in toggling 0110000/1111111 every sample on digit 1: no capture, bcd_out[7:4] stays F.
REQ-030 SHALL check digits 1,2,3,4 captured on positions 0..3 in turn: frame_done high for exactly one cycle after the last capture, and bcd_out=16'h4321.
REQ-031 SHALL check pattern 1010101 captured on digit 2 with the macro defined: bcd_out[11:8]=E, digit_valid[2]=0, pattern_err=1; with err_clr and a new illegal capture in the same cycle, pattern_err stays 1.
REQ-032 SHALL check digit_sel=0011 for 5 samples: no capture and state IDLE; and reset_n pulsed low during SETTLE: outputs return to reset values immediately.
REQ-033 SHALL check sample_en=0 with changing inputs: no state, count or output change.
